// File: rtl/ddr_read_arbiter.sv
`default_nettype none
// ============================================================================
// ddr_read_arbiter: round-robin sharing of one DDR read port among FUs
// Revision: 1.0
// ============================================================================
module ddr_read_arbiter #(
    parameter int NumRequesters = 4,
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NumRequesters-1:0][AddrWidth-1:0] req_addr_i,
    input  logic [NumRequesters-1:0]                req_r_en_i,
    output logic [DataWidth-1:0]                    req_r_data_o,
    output logic [NumRequesters-1:0]                req_r_valid_o,
    output logic [AddrWidth-1:0]                    ddr_address_o,
    output logic                                    ddr_r_en_o,
    input  logic [DataWidth-1:0]                    ddr_r_data_i,
    input  logic                                    ddr_r_valid_i,
    output logic                                    busy_o,
    output logic                                    err_o
);

    localparam int IdxW = $clog2(NumRequesters);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [NumRequesters-1:0] pending_q, pending_d;
    logic [AddrWidth-1:0]     addr_q [NumRequesters];
    logic [AddrWidth-1:0]     addr_d [NumRequesters];
    logic [IdxW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]          owner_q, owner_d;
    logic                     ddr_r_en_q, ddr_r_en_d;
    logic [AddrWidth-1:0]     ddr_addr_q, ddr_addr_d;
    logic                     err_q, err_d;

    logic [IdxW-1:0]          w_winner;
    logic [IdxW-1:0]          w_scan;
    logic                     w_found;
    logic                     w_resp;
    logic [NumRequesters-1:0] w_clr;
    logic [NumRequesters-1:0] w_dup;

    function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
        if (idx == IdxW'(NumRequesters - 1)) begin
            return '0;
        end
        return idx + IdxW'(1);
    endfunction

    // Cyclic search for the first pending requester at or above rr_ptr.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = rr_ptr_q;
        for (int i = 0; i < NumRequesters; i++) begin
            if (!w_found && pending_q[w_scan]) begin
                w_found  = 1'b1;
                w_winner = w_scan;
            end
            w_scan = wrap_inc(w_scan);
        end
    end

    assign w_resp = (state_q == WAIT) && ddr_r_valid_i;

    always_comb begin
        w_clr = '0;
        if (w_resp) begin
            w_clr[owner_q] = 1'b1;
        end
    end

    // A re-pulse from the owner in its response cycle is a fresh request, not a duplicate.
    assign w_dup = req_r_en_i & pending_q & ~w_clr;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        addr_d     = addr_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        ddr_r_en_d = 1'b0;
        ddr_addr_d = ddr_addr_q;
        err_d      = err_q | (|w_dup) | (ddr_r_valid_i && (state_q != WAIT));

        for (int k = 0; k < NumRequesters; k++) begin
            if (w_clr[k]) begin
                pending_d[k] = 1'b0;
            end
            if (req_r_en_i[k] && !w_dup[k]) begin
                pending_d[k] = 1'b1;
                addr_d[k]    = req_addr_i[k];
            end
        end

        case (state_q)
            IDLE: begin
                if (w_found) begin
                    owner_d    = w_winner;
                    ddr_r_en_d = 1'b1;
                    ddr_addr_d = addr_q[w_winner];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (ddr_r_valid_i) begin
                    rr_ptr_d = wrap_inc(owner_q);
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            ddr_r_en_q <= 1'b0;
            ddr_addr_q <= '0;
            err_q      <= 1'b0;
            for (int k = 0; k < NumRequesters; k++) begin
                addr_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            ddr_r_en_q <= ddr_r_en_d;
            ddr_addr_q <= ddr_addr_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
        end
    end

    assign req_r_data_o  = ddr_r_data_i;
    assign req_r_valid_o = w_clr;
    assign ddr_address_o = ddr_addr_q;
    assign ddr_r_en_o    = ddr_r_en_q;
    assign busy_o        = (|pending_q) || (state_q != IDLE);
    assign err_o         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_read_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ddr_read_arbiter: directed bench with a cycle-level reference model
// Revision: 1.0
// ============================================================================
module tb_ddr_read_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 3;

    logic                 clk;
    logic                 rst_ni;
    logic [N-1:0][AW-1:0] req_addr_i;
    logic [N-1:0]         req_r_en_i;
    logic [DW-1:0]        req_r_data_o;
    logic [N-1:0]         req_r_valid_o;
    logic [AW-1:0]        ddr_address_o;
    logic                 ddr_r_en_o;
    logic [DW-1:0]        ddr_r_data_i;
    logic                 ddr_r_valid_i;
    logic                 busy_o;
    logic                 err_o;

    ddr_read_arbiter #(
        .NumRequesters(N),
        .AddrWidth    (AW),
        .DataWidth    (DW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_addr_i   (req_addr_i),
        .req_r_en_i   (req_r_en_i),
        .req_r_data_o (req_r_data_o),
        .req_r_valid_o(req_r_valid_o),
        .ddr_address_o(ddr_address_o),
        .ddr_r_en_o   (ddr_r_en_o),
        .ddr_r_data_i (ddr_r_data_i),
        .ddr_r_valid_i(ddr_r_valid_i),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: requests are a pending set; a grant made in cycle c
    // puts the read on the DDR bus in cycle c+1 and waits from c+2 onwards.
    logic [N-1:0]  m_pend;
    logic [AW-1:0] m_addr [N];
    int            m_ptr;
    int            m_owner;
    int            m_issue;
    int            m_cyc;
    logic          m_err;
    logic [AW-1:0] m_last_addr;

    logic [AW-1:0] issued_q [$];
    logic [N-1:0]  valid_q  [$];

    bit            auto_ddr;
    int            dcount;
    logic [AW-1:0] d_addr;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pend      = '0;
        m_ptr       = 0;
        m_owner     = -1;
        m_issue     = 0;
        m_cyc       = 0;
        m_err       = 1'b0;
        m_last_addr = '0;
        for (int k = 0; k < N; k++) m_addr[k] = '0;
    endtask

    task automatic model_step();
        bit         waiting;
        logic       exp_ren;
        logic [N-1:0] exp_valid;
        bit         any_p;
        int         w;
        if (!rst_ni) begin
            m_reset();
            return;
        end
        m_cyc++;
        waiting   = (m_owner >= 0) && (m_cyc > m_issue);
        exp_ren   = (m_owner >= 0) && (m_cyc == m_issue);
        exp_valid = (waiting && ddr_r_valid_i) ? N'(1 << m_owner) : '0;
        any_p     = |m_pend;

        check("ddr_r_en", 32'(ddr_r_en_o), 32'(exp_ren));
        check("ddr_address", ddr_address_o, m_last_addr);
        check("req_r_valid", 32'(req_r_valid_o), 32'(exp_valid));
        check("req_r_data", req_r_data_o, ddr_r_data_i);
        check("busy", 32'(busy_o), 32'(any_p || (m_owner >= 0)));
        check("err", 32'(err_o), 32'(m_err));

        if (ddr_r_en_o) issued_q.push_back(ddr_address_o);
        if (req_r_valid_o != '0) valid_q.push_back(req_r_valid_o);

        if (m_owner < 0 && any_p) begin
            w = -1;
            for (int i = 0; i < N; i++) begin
                if (w < 0 && m_pend[(m_ptr + i) % N]) w = (m_ptr + i) % N;
            end
            m_owner     = w;
            m_issue     = m_cyc + 1;
            m_last_addr = m_addr[w];
        end else if (exp_valid != '0) begin
            m_pend[m_owner] = 1'b0;
            m_ptr           = (m_owner + 1) % N;
            m_owner         = -1;
        end
        if (ddr_r_valid_i && !waiting) m_err = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (req_r_en_i[k]) begin
                if (m_pend[k]) m_err = 1'b1;
                else begin
                    m_pend[k] = 1'b1;
                    m_addr[k] = req_addr_i[k];
                end
            end
        end
    endtask

    // One clock cycle: model compare at the falling edge, then fresh inputs
    // just after the rising edge. Pulses last exactly one cycle.
    task automatic cyc();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        req_r_en_i    = '0;
        ddr_r_valid_i = 1'b0;
        if (auto_ddr) begin
            if (dcount == 0) begin
                ddr_r_valid_i = 1'b1;
                ddr_r_data_i  = d_addr ^ 32'hA5A5_0000;
            end
            if (dcount >= 0) dcount--;
            if (ddr_r_en_o) begin
                dcount = LAT - 1;
                d_addr = ddr_address_o;
            end
        end
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (busy_o && n < max);
        check("idle_timeout", 32'(busy_o), 32'd0);
    endtask

    logic [AW-1:0] exp_order [4];
    logic [N-1:0]  exp_route [4];

    initial begin
        rst_ni        = 1'b0;
        req_addr_i    = '0;
        req_r_en_i    = '0;
        ddr_r_data_i  = '0;
        ddr_r_valid_i = 1'b0;
        auto_ddr      = 1'b0;
        dcount        = -1;
        d_addr        = '0;
        m_reset();

        #2;
        check("rst_ddr_r_en", 32'(ddr_r_en_o), 32'd0);
        check("rst_ddr_address", ddr_address_o, 32'd0);
        check("rst_req_r_valid", 32'(req_r_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        cyc();
        cyc();
        rst_ni = 1'b1;
        cyc();

        // All four at once from rr_ptr=0.
        auto_ddr = 1'b1;
        issued_q.delete();
        valid_q.delete();
        for (int k = 0; k < N; k++) req_addr_i[k] = 32'(k * 16);
        req_r_en_i = 4'b1111;
        wait_idle(100);
        exp_order = '{32'h00, 32'h10, 32'h20, 32'h30};
        exp_route = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        check("simul_issue_count", 32'(issued_q.size()), 32'd4);
        check("simul_valid_count", 32'(valid_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < issued_q.size()) check("simul_order", issued_q[i], exp_order[i]);
            if (i < valid_q.size()) check("simul_route", 32'(valid_q[i]), 32'(exp_route[i]));
        end

        // Single read with a hand-timed DDR response.
        auto_ddr = 1'b0;
        dcount   = -1;
        req_addr_i[1] = 32'h40;
        req_r_en_i    = 4'b0010;
        cyc(); #2;
        check("single_busy_t1", 32'(busy_o), 32'd1);
        check("single_noissue_t1", 32'(ddr_r_en_o), 32'd0);
        cyc(); #2;
        check("single_ren_t2", 32'(ddr_r_en_o), 32'd1);
        check("single_addr_t2", ddr_address_o, 32'h40);
        cyc(); #2;
        check("single_ren_t3", 32'(ddr_r_en_o), 32'd0);
        cyc();
        cyc();
        ddr_r_valid_i = 1'b1;
        ddr_r_data_i  = 32'hAB;
        #2;
        check("single_valid_t5", 32'(req_r_valid_o), 32'b0010);
        check("single_data_t5", req_r_data_o, 32'hAB);
        cyc(); #2;
        check("single_busy_t6", 32'(busy_o), 32'd0);

        // Fairness: grant 2, then 0 and 3 pending -> 3 before 0.
        auto_ddr = 1'b1;
        issued_q.delete();
        req_addr_i[2] = 32'h120;
        req_r_en_i    = 4'b0100;
        cyc();
        cyc();
        cyc();
        req_addr_i[0] = 32'h100;
        req_addr_i[3] = 32'h130;
        req_r_en_i    = 4'b1001;
        wait_idle(100);
        check("fair_count", 32'(issued_q.size()), 32'd3);
        if (issued_q.size() == 3) begin
            check("fair_first", issued_q[0], 32'h120);
            check("fair_second", issued_q[1], 32'h130);
            check("fair_third", issued_q[2], 32'h100);
        end

        // Back-to-back: requester 0 re-pulses in its response cycle.
        auto_ddr = 1'b0;
        dcount   = -1;
        req_addr_i[0] = 32'h300;
        req_r_en_i    = 4'b0001;
        cyc();
        cyc();
        cyc();
        cyc();
        cyc();
        ddr_r_valid_i = 1'b1;
        ddr_r_data_i  = 32'h5A;
        req_addr_i[0] = 32'h304;
        req_r_en_i    = 4'b0001;
        #2;
        check("b2b_valid", 32'(req_r_valid_o), 32'b0001);
        cyc(); #2;
        check("b2b_busy", 32'(busy_o), 32'd1);
        cyc(); #2;
        check("b2b_ren", 32'(ddr_r_en_o), 32'd1);
        check("b2b_addr", ddr_address_o, 32'h304);
        check("b2b_err", 32'(err_o), 32'd0);
        cyc();
        cyc();
        ddr_r_valid_i = 1'b1;
        ddr_r_data_i  = 32'h6B;
        wait_idle(20);

        // Double pulse from requester 2: first address wins, one response.
        auto_ddr = 1'b1;
        issued_q.delete();
        valid_q.delete();
        req_addr_i[2] = 32'h220;
        req_r_en_i    = 4'b0100;
        cyc();
        req_addr_i[2] = 32'h228;
        req_r_en_i    = 4'b0100;
        cyc(); #2;
        check("dup_err", 32'(err_o), 32'd1);
        wait_idle(100);
        check("dup_issue_count", 32'(issued_q.size()), 32'd1);
        if (issued_q.size() == 1) check("dup_addr", issued_q[0], 32'h220);
        check("dup_resp_count", 32'(valid_q.size()), 32'd1);

        // Reset in WAIT, late response, then arbitration restarts at 0.
        auto_ddr = 1'b0;
        dcount   = -1;
        req_addr_i[1] = 32'h410;
        req_r_en_i    = 4'b0010;
        cyc();
        cyc();
        cyc();
        cyc();
        #1;
        rst_ni = 1'b0;
        #1;
        check("arst_ddr_r_en", 32'(ddr_r_en_o), 32'd0);
        check("arst_ddr_address", ddr_address_o, 32'd0);
        check("arst_req_r_valid", 32'(req_r_valid_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_err", 32'(err_o), 32'd0);
        cyc();
        cyc();
        rst_ni        = 1'b1;
        ddr_r_valid_i = 1'b1;
        ddr_r_data_i  = 32'h77;
        #2;
        check("late_valid", 32'(req_r_valid_o), 32'd0);
        cyc(); #2;
        check("late_err", 32'(err_o), 32'd1);
        auto_ddr = 1'b1;
        issued_q.delete();
        req_addr_i[1] = 32'h510;
        req_addr_i[3] = 32'h530;
        req_r_en_i    = 4'b1010;
        wait_idle(100);
        check("post_rst_count", 32'(issued_q.size()), 32'd2);
        if (issued_q.size() == 2) begin
            check("post_rst_first", issued_q[0], 32'h510);
            check("post_rst_second", issued_q[1], 32'h530);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
